itrx_aib_phy_repair_dec: RTL and testbench
==========================================

// Module: itrx_aib_phy_repair_dec
// PURPOSE
//  Inverse of the AIB repair encoder: recovers spec-format repair info (11b: [10]=dir TX/RX, [9:0]=index)
//  from a 45b redun_engage shift vector (e.g. read back from the IO chain or a repair register).
//  Sequential scan outward from the spare-bit centre, 1 index/cycle; flags malformed vectors.
//  Sits in the repair/BIST readback path beside the repair encoder, one instance per AIB channel.
// PARAMETERS
//  CHK_EN   1   1: re-encode decoded result and compare to captured vector; mismatch -> dec_err
// PORTS
//  clk              in   1   block clock
//  rst_n            in   1   async active-low reset
//  start            in   1   1-cycle pulse: capture redun_engage, begin decode
//  redun_engage     in   45  shift vector to decode; sampled only on accepted start
//  busy             out  1   decode in progress
//  done             out  1   1-cycle pulse: result registers valid from this cycle
//  repair_info_nvm  out  11  decoded {dir, index}; 0 when no repair or error
//  repair_info_vld  out  1   decoded vector is a legal single repair
//  dec_err          out  1   vector illegal (non-thermometer, both dirs, bad centre bits)
// BEHAVIOUR
//  Interface: one clock (clk); asynchronous active-low reset (rst_n).
//  Reset: all outputs 0; FSM=IDLE; shadow vector, counter, run flags 0.
//  Legal vectors (n=0..21): TX n -> bits[22:21-n]=1, rest 0 (n=0 -> 45'h60_0000; n=21 -> 45'h7F_FFFF).
//   RX n -> bits[23+n:23]=1, rest 0 (n=0 -> 45'h80_0000; n=21 -> 45'h1FFF_FF80_0000). All-zero = no repair.
//  FSM IDLE -> SCAN -> RES -> IDLE.
//   IDLE/RES: start=1 -> capture vector into shadow, k=0, clear flags, busy=1, goto SCAN.
//   SCAN (k=0..21, 22 cycles): examine tx_bit=shadow[21-k], rx_bit=shadow[23+k].
//    tx run: first 0 seen sets tx_end; a 1 after tx_end -> err. Same for rx. tx_len/rx_len count 1s.
//    k==21 -> goto RES.
//   RES (1 cycle): evaluate, register outputs, done=1, busy=0, then IDLE.
//    tx_any=shadow[22]|tx_len!=0; rx_any=rx_len!=0.
//    err if: tx_any&rx_any | shadow[22]!=shadow[21] | shadow[22]==0&tx_len!=0 | any run break.
//    TX ok: info={1'b1, 10'(tx_len-1)}, vld=1. RX ok: info={1'b0, 10'(rx_len-1)}, vld=1.
//    all-zero: info=0, vld=0, err=0. err: info=0, vld=0, err=1.
//    CHK_EN=1: enc(info,vld)!=shadow with err=0 -> force err=1, vld=0, info=0 (redundant guard).
//  Latency: start at cycle T -> done at T+23; outputs hold until next done or reset.
//  start during SCAN: ignored (no restart, no queue). start in RES cycle: accepted as IDLE.
//  redun_engage changes after capture: no effect on the in-flight decode.
//  Widths: tx_len/rx_len 5b (max 22); index zero-extended to 10b; no wrap possible.
//  rst_n asserted mid-scan: abort, outputs 0, no done pulse.
// STRUCTURE
//  Package itrx_aib_phy_repair_pkg: REDUN_W=45, TX_MSB=22, RX_LSB=23, MAX_IDX=21, INFO_W=11,
//   typedef enum logic[1:0] {ST_IDLE, ST_SCAN, ST_RES} repair_dec_st_t; shared with the encoder.
//  Sub-module: itrx_aib_phy_repair_enc (existing encoder), one instance under CHK_EN for cross-check.
//  Rest flat: FSM, 5b scan counter, 45b shadow, 2 run trackers, output regs.
// TESTING
//  1 start, vector 45'h7F_FFFF -> done at +23, info=11'h415 (TX,21), vld=1, err=0.
//  2 start, vector 45'h80_0000 -> info=11'h000, vld=1, err=0; 45'h60_0000 -> info=11'h400, vld=1.
//  3 start, vector 0 -> info=0, vld=0, err=0; then 45'h7F_0000 (TX 5) -> info=11'h405, vld=1.
//  4 illegal: 45'h40_0000, 45'hE0_0000 (both), 45'h7D_0000 (gap) -> err=1, vld=0, info=0.
//  5 start pulsed at +5 during scan and vector changed -> ignored, result of original vector;
//    rst_n low at +10 -> outputs 0, no done; next start decodes normally.
//  6 exhaustive loop: all 44 legal {dir,n} through encoder -> decoder returns identical info, vld=1.

Source files
------------

// File: rtl/itrx_aib_phy_repair_pkg.sv
// itrx_aib_phy_repair_pkg
//   Shared constants and types for the AIB repair encoder/decoder pair.
//   Vector layout (45b redun_engage): bit 22 is the TX centre bit, TX runs
//   extend downward from bit 21, RX runs extend upward from bit 23.
//   Repair info (11b): [10] = direction (1 = TX, 0 = RX), [9:0] = index.
package itrx_aib_phy_repair_pkg;

    localparam int REDUN_W = 45;
    localparam int TX_MSB  = 22;
    localparam int RX_LSB  = 23;
    localparam int MAX_IDX = 21;
    localparam int INFO_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RES  = 2'd2
    } repair_dec_st_t;

endpackage

// File: rtl/itrx_aib_phy_repair_enc.sv
// itrx_aib_phy_repair_enc
//   Combinational repair encoder: {dir, index} + valid -> 45b redun_engage.
//   TX n sets bits [22:21-n]; RX n sets bits [23+n:23]. Invalid input or an
//   index beyond the spare range yields the all-zero (no repair) vector.
// Ports
//   repair_info   in   11  {dir, index}
//   repair_vld    in   1   repair_info holds a real repair
//   redun_engage  out  45  encoded shift vector
module itrx_aib_phy_repair_enc
    import itrx_aib_phy_repair_pkg::*;
(
    input  logic [INFO_W-1:0]  repair_info,
    input  logic               repair_vld,
    output logic [REDUN_W-1:0] redun_engage
);

    logic       dir;
    logic [9:0] idx;

    assign dir = repair_info[INFO_W-1];
    assign idx = repair_info[9:0];

    always_comb begin
        redun_engage = '0;
        if (repair_vld && (idx <= 10'(MAX_IDX))) begin
            if (dir) begin
                redun_engage[TX_MSB] = 1'b1;
            end
            for (int i = 0; i <= MAX_IDX; i++) begin
                if (10'(i) <= idx) begin
                    if (dir) begin
                        redun_engage[TX_MSB-1-i] = 1'b1;
                    end else begin
                        redun_engage[RX_LSB+i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/itrx_aib_phy_repair_dec.sv
// itrx_aib_phy_repair_dec
//   Recovers {dir, index} repair info from a 45b redun_engage shift vector.
//   The captured vector is scanned outward from the spare centre, one bit
//   position per direction per cycle (22 cycles), then judged in one result
//   cycle. Malformed vectors (broken runs, both directions, bad centre
//   bits) raise dec_err.
// Ports
//   clk              in   1   block clock
//   rst_n            in   1   async active-low reset
//   start            in   1   pulse: capture redun_engage, begin decode
//   redun_engage     in   45  vector to decode, sampled on accepted start
//   busy             out  1   decode in progress
//   done             out  1   pulse: result outputs valid from this cycle
//   repair_info_nvm  out  11  decoded {dir, index}; 0 on no repair / error
//   repair_info_vld  out  1   vector is a legal single repair
//   dec_err          out  1   vector is illegal
module itrx_aib_phy_repair_dec
    import itrx_aib_phy_repair_pkg::*;
#(
    parameter bit CHK_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [REDUN_W-1:0] redun_engage,
    output logic               busy,
    output logic               done,
    output logic [INFO_W-1:0]  repair_info_nvm,
    output logic               repair_info_vld,
    output logic               dec_err
);

    repair_dec_st_t     state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [REDUN_W-1:0] shadow_q, shadow_d;
    logic [4:0]         tx_len_q, tx_len_d, rx_len_q, rx_len_d;
    logic               tx_end_q, tx_end_d, rx_end_q, rx_end_d;
    logic               tx_brk_q, tx_brk_d, rx_brk_q, rx_brk_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic [INFO_W-1:0]  info_q, info_d;
    logic               vld_q, vld_d, err_q, err_d;

    // Per-cycle scan step: tracker values after absorbing the bit pair at k
    logic [MAX_IDX:0]   tx_vec, rx_vec;
    logic               tx_bit, rx_bit;
    logic [4:0]         tx_len_nxt, rx_len_nxt;
    logic               tx_end_nxt, rx_end_nxt, tx_brk_nxt, rx_brk_nxt;

    // Result judged from the post-step trackers on the last scan cycle
    logic               tx_any, rx_any, err_raw, vld_raw, chk_mis;
    logic [INFO_W-1:0]  info_raw;

    assign tx_vec = shadow_q[TX_MSB-1:0];
    assign rx_vec = shadow_q[REDUN_W-1:RX_LSB];
    // TX runs grow downward, so the TX bit is taken from the top of its slice
    assign tx_bit = tx_vec[5'(MAX_IDX) - cnt_q];
    assign rx_bit = rx_vec[cnt_q];

    always_comb begin
        tx_len_nxt = tx_len_q;
        tx_end_nxt = tx_end_q;
        tx_brk_nxt = tx_brk_q;
        rx_len_nxt = rx_len_q;
        rx_end_nxt = rx_end_q;
        rx_brk_nxt = rx_brk_q;
        if (tx_bit) begin
            tx_len_nxt = tx_len_q + 5'd1;
            if (tx_end_q) tx_brk_nxt = 1'b1;
        end else begin
            tx_end_nxt = 1'b1;
        end
        if (rx_bit) begin
            rx_len_nxt = rx_len_q + 5'd1;
            if (rx_end_q) rx_brk_nxt = 1'b1;
        end else begin
            rx_end_nxt = 1'b1;
        end
    end

    always_comb begin
        tx_any   = shadow_q[TX_MSB] | (tx_len_nxt != 5'd0);
        rx_any   = (rx_len_nxt != 5'd0);
        err_raw  = (tx_any & rx_any)
                 | (shadow_q[TX_MSB] != shadow_q[TX_MSB-1])
                 | (~shadow_q[TX_MSB] & (tx_len_nxt != 5'd0))
                 | tx_brk_nxt | rx_brk_nxt;
        info_raw = '0;
        vld_raw  = 1'b0;
        if (!err_raw) begin
            if (tx_any) begin
                info_raw = {1'b1, 5'd0, 5'(tx_len_nxt - 5'd1)};
                vld_raw  = 1'b1;
            end else if (rx_any) begin
                info_raw = {1'b0, 5'd0, 5'(rx_len_nxt - 5'd1)};
                vld_raw  = 1'b1;
            end
        end
    end

    // Re-encode the verdict and compare against the captured vector; catches
    // any case the run checks above might let through.
    generate
        if (CHK_EN) begin : g_chk
            logic [REDUN_W-1:0] enc_vec;
            itrx_aib_phy_repair_enc u_enc (
                .repair_info  (info_raw),
                .repair_vld   (vld_raw),
                .redun_engage (enc_vec)
            );
            assign chk_mis = (enc_vec != shadow_q) & ~err_raw;
        end else begin : g_nochk
            assign chk_mis = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        tx_len_d = tx_len_q;
        rx_len_d = rx_len_q;
        tx_end_d = tx_end_q;
        rx_end_d = rx_end_q;
        tx_brk_d = tx_brk_q;
        rx_brk_d = rx_brk_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        info_d   = info_q;
        vld_d    = vld_q;
        err_d    = err_q;
        case (state_q)
            ST_SCAN: begin
                // start is deliberately ignored here: no restart, no queue
                tx_len_d = tx_len_nxt;
                rx_len_d = rx_len_nxt;
                tx_end_d = tx_end_nxt;
                rx_end_d = rx_end_nxt;
                tx_brk_d = tx_brk_nxt;
                rx_brk_d = rx_brk_nxt;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'(MAX_IDX)) begin
                    // Result registered on entry to RES so done lines up
                    // with the RES cycle itself.
                    state_d = ST_RES;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (chk_mis) begin
                        info_d = '0;
                        vld_d  = 1'b0;
                        err_d  = 1'b1;
                    end else begin
                        info_d = info_raw;
                        vld_d  = vld_raw;
                        err_d  = err_raw;
                    end
                end
            end
            ST_IDLE, ST_RES: begin
                state_d = ST_IDLE;
                if (start) begin
                    state_d  = ST_SCAN;
                    shadow_d = redun_engage;
                    cnt_d    = 5'd0;
                    tx_len_d = 5'd0;
                    rx_len_d = 5'd0;
                    tx_end_d = 1'b0;
                    rx_end_d = 1'b0;
                    tx_brk_d = 1'b0;
                    rx_brk_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            tx_len_q <= '0;
            rx_len_q <= '0;
            tx_end_q <= 1'b0;
            rx_end_q <= 1'b0;
            tx_brk_q <= 1'b0;
            rx_brk_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            info_q   <= '0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            tx_len_q <= tx_len_d;
            rx_len_q <= rx_len_d;
            tx_end_q <= tx_end_d;
            rx_end_q <= rx_end_d;
            tx_brk_q <= tx_brk_d;
            rx_brk_q <= rx_brk_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            info_q   <= info_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign repair_info_nvm = info_q;
    assign repair_info_vld = vld_q;
    assign dec_err         = err_q;

endmodule

// File: tb/tb_itrx_aib_phy_repair_dec.sv
// tb_itrx_aib_phy_repair_dec
//   Directed checks of the repair decoder: legal TX/RX/no-repair vectors,
//   illegal vectors, start-during-scan, mid-scan reset and a sweep of all
//   44 legal repairs produced by the encoder.
module tb_itrx_aib_phy_repair_dec;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [44:0] redun_engage;
    logic        busy, done, repair_info_vld, dec_err;
    logic [10:0] repair_info_nvm;

    logic [10:0] enc_info;
    logic        enc_vld;
    logic [44:0] enc_vec;

    int checks = 0;
    int fails  = 0;

    itrx_aib_phy_repair_dec #(.CHK_EN(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .redun_engage    (redun_engage),
        .busy            (busy),
        .done            (done),
        .repair_info_nvm (repair_info_nvm),
        .repair_info_vld (repair_info_vld),
        .dec_err         (dec_err)
    );

    itrx_aib_phy_repair_enc u_ref_enc (
        .repair_info  (enc_info),
        .repair_vld   (enc_vld),
        .redun_engage (enc_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start high for exactly one rising edge (cycle T); returns in cycle T+1.
    task automatic pulse_start(input logic [44:0] v);
        @(negedge clk);
        redun_engage = v;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    // Cycle number (relative to the start cycle T) at which done is seen;
    // 99 if done never arrives within the budget.
    task automatic wait_done(input int cyc_now, output int cyc);
        cyc = 99;
        for (int i = cyc_now; i < cyc_now + 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = i + 1;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [44:0] v,
                       input logic [10:0] e_info, input logic e_vld, input logic e_err);
        int cyc;
        pulse_start(v);
        wait_done(1, cyc);
        chk({tag, ".lat"},  64'(cyc), 64'd23);
        chk({tag, ".info"}, 64'(repair_info_nvm), 64'(e_info));
        chk({tag, ".vld"},  64'(repair_info_vld), 64'(e_vld));
        chk({tag, ".err"},  64'(dec_err), 64'(e_err));
        chk({tag, ".busy"}, 64'(busy), 64'd0);
    endtask

    function automatic logic [44:0] mk_vec(input logic dir, input int n);
        logic [44:0] v;
        v = '0;
        if (dir) begin
            for (int i = 21 - n; i <= 22; i++) v[i] = 1'b1;
        end else begin
            for (int i = 23; i <= 23 + n; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    initial begin
        int          cyc;
        int          seen;
        logic [44:0] v;

        rst_n        = 1'b0;
        start        = 1'b0;
        redun_engage = '0;
        enc_info     = '0;
        enc_vld      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.info", 64'(repair_info_nvm), 64'd0);
        chk("rst.vld",  64'(repair_info_vld), 64'd0);
        chk("rst.err",  64'(dec_err), 64'd0);
        rst_n = 1'b1;

        // 1: TX 21, plus one-cycle done pulse and busy during scan
        pulse_start(45'h7F_FFFF);
        chk("t1.busy_scan", 64'(busy), 64'd1);
        wait_done(1, cyc);
        chk("t1.lat",  64'(cyc), 64'd23);
        chk("t1.info", 64'(repair_info_nvm), 64'h415);
        chk("t1.vld",  64'(repair_info_vld), 64'd1);
        chk("t1.err",  64'(dec_err), 64'd0);
        @(posedge clk);
        #1;
        chk("t1.done_pulse", 64'(done), 64'd0);
        chk("t1.hold_info",  64'(repair_info_nvm), 64'h415);

        // 2: RX 0, TX 0 (back to back, start accepted in the RES cycle)
        run("t2.rx0", 45'h80_0000, 11'h000, 1'b1, 1'b0);
        run("t2.tx0", 45'h60_0000, 11'h400, 1'b1, 1'b0);
        run("t2.rx21", 45'h1FFF_FF80_0000, 11'h015, 1'b1, 1'b0);

        // 3: no repair, then TX 5
        run("t3.zero", 45'h0, 11'h000, 1'b0, 1'b0);
        run("t3.tx5",  45'h7F_0000, 11'h405, 1'b1, 1'b0);

        // 4: illegal vectors
        run("t4.ctr",  45'h40_0000, 11'h000, 1'b0, 1'b1);
        run("t4.both", 45'hE0_0000, 11'h000, 1'b0, 1'b1);
        run("t4.gap",  45'h7D_0000, 11'h000, 1'b0, 1'b1);
        run("t4.nctr", 45'h20_0000, 11'h000, 1'b0, 1'b1);

        // 5a: start pulse and vector change at T+5 are ignored
        pulse_start(45'h7F_0000);
        repeat (4) @(negedge clk);
        redun_engage = 45'h80_0000;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        wait_done(6, cyc);
        chk("t5.lat",  64'(cyc), 64'd23);
        chk("t5.info", 64'(repair_info_nvm), 64'h405);
        chk("t5.vld",  64'(repair_info_vld), 64'd1);

        // 5b: reset at T+10 aborts the decode with no done pulse
        pulse_start(45'h7F_FFFF);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5.rst_info", 64'(repair_info_nvm), 64'd0);
        chk("t5.rst_vld",  64'(repair_info_vld), 64'd0);
        chk("t5.rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("t5.no_done", 64'(seen), 64'd0);
        run("t5.after", 45'h7F_FFFF, 11'h415, 1'b1, 1'b0);

        // 6: every legal repair through the encoder and back
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n <= 21; n++) begin
                v        = mk_vec(d[0], n);
                enc_info = {d[0], 10'(n)};
                enc_vld  = 1'b1;
                #1;
                chk($sformatf("t6.enc d%0d n%0d", d, n), 64'(enc_vec), 64'(v));
                run($sformatf("t6.dec d%0d n%0d", d, n), enc_vec, {d[0], 10'(n)}, 1'b1, 1'b0);
            end
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
